// File: rtl/ula_pkg.sv
// Shared ULA definitions: input-sequencing state encodings and default timing.
// Used by the input sequencer and by the LED/display stage that decodes state.
// Contents: ESPERA_A/A_OK/B_OK/OP_OK encodings, state width, default debounce length.
package ula_pkg;

  localparam int SEQ_STATE_W = 2;

  // Sequencing states, in the order operands are entered.
  localparam logic [SEQ_STATE_W-1:0] ESPERA_A = 2'b00;  // waiting for operand A
  localparam logic [SEQ_STATE_W-1:0] A_OK     = 2'b01;  // A latched, waiting for B
  localparam logic [SEQ_STATE_W-1:0] B_OK     = 2'b10;  // B latched, waiting for opcode
  localparam logic [SEQ_STATE_W-1:0] OP_OK    = 2'b11;  // all latched, next press clears

  // 1 ms at 50 MHz.
  localparam int DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/sequenciador_entradas_debounce.sv
// debounce_botao: 2-flop synchronizer, counting debouncer and fall-edge press detector.
// Latency: press is high DEBOUNCE_CYCLES+2 edges after a clean fall is first sampled.
// No backpressure: press is a one-cycle strobe, held levels yield a single press.
// Ports: clk, rst_n (async, active-low), btn_n (raw active-low button), press (1-cycle pulse).
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_sync_vld;  // marks when r_sync holds real samples rather than reset values
  logic          r_stable;
  logic          r_stable_d;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          w_sync;

  assign w_sync = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b11;
      r_sync_vld <= 2'b00;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync     <= {r_sync[0], btn_n};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_stable_d <= r_stable;

      // A button held across reset must be seen released before any press counts.
      if (r_sync_vld[1] && w_sync) begin
        r_armed <= 1'b1;
      end

      if (w_sync != r_stable) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= w_sync;
          r_cnt    <= '0;
        end else if (r_cnt != CW'(DEBOUNCE_CYCLES)) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Only the 1->0 transition of the stable level is a press; release is silent.
  assign press = r_armed & r_stable_d & ~r_stable;

endmodule

// File: rtl/sequenciador_entradas.sv
// Input sequencer: latches operand A, operand B and opcode on successive debounced presses.
// Latency: DEBOUNCE_CYCLES+3 cycles from a clean KEY_confirma fall to register/state update.
// No backpressure: op_start is a one-cycle strobe; SW is ignored between presses.
// Ports: clk, rst_n (async, active-low), KEY_confirma (raw active-low button), SW[7:0],
//        state[1:0], A_registered[7:0], B_registered[7:0], OP_registered[2:0], op_start.
module sequenciador_entradas
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       KEY_confirma,
  input  logic [7:0] SW,
  output logic [1:0] state,
  output logic [7:0] A_registered,
  output logic [7:0] B_registered,
  output logic [2:0] OP_registered,
  output logic       op_start
);

  logic       w_press;
  logic [1:0] r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_op;
  logic       r_op_start;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (KEY_confirma),
    .press (w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ESPERA_A;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_op_start <= 1'b0;
    end else begin
      r_op_start <= 1'b0;
      if (w_press) begin
        case (r_state)
          ESPERA_A: begin
            r_a     <= SW;
            r_state <= A_OK;
          end
          A_OK: begin
            r_b     <= SW;
            r_state <= B_OK;
          end
          B_OK: begin
            r_op       <= SW[2:0];
            r_state    <= OP_OK;
            // Registered so it rises together with the completed operand set.
            r_op_start <= 1'b1;
          end
          default: begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_state <= ESPERA_A;
          end
        endcase
      end
    end
  end

  assign state         = r_state;
  assign A_registered  = r_a;
  assign B_registered  = r_b;
  assign OP_registered = r_op;
  assign op_start      = r_op_start;

endmodule

// File: tb/tb_sequenciador_entradas.sv
module tb_sequenciador_entradas;

  localparam int DEB = 4;

  logic       clk;
  logic       rst_n;
  logic       KEY_confirma;
  logic [7:0] SW;
  logic [1:0] state;
  logic [7:0] A_registered;
  logic [7:0] B_registered;
  logic [2:0] OP_registered;
  logic       op_start;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  sequenciador_entradas #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .KEY_confirma  (KEY_confirma),
    .SW            (SW),
    .state         (state),
    .A_registered  (A_registered),
    .B_registered  (B_registered),
    .OP_registered (OP_registered),
    .op_start      (op_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count op_start cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (op_start === 1'b1) pulse_cnt = pulse_cnt + 1;
  end

  typedef struct {
    logic [7:0] sw;
    logic [1:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         pulses;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] sw);
    @(negedge clk);
    SW = sw;
    KEY_confirma = 1'b0;
    wait_cycles(12);
    KEY_confirma = 1'b1;
    wait_cycles(12);
  endtask

  task automatic check_all(input string name, input logic [1:0] st, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op);
    chk({name, ".state"}, int'(state), int'(st));
    chk({name, ".A"}, int'(A_registered), int'(a));
    chk({name, ".B"}, int'(B_registered), int'(b));
    chk({name, ".OP"}, int'(OP_registered), int'(op));
  endtask

  initial begin
    int p0;
    int cyc;
    int trans;
    logic [1:0] prev;

    //              sw     st     a      b      op    pulses
    tbl[0] = '{8'h2A, 2'b01, 8'h2A, 8'h00, 3'd0, 0};
    tbl[1] = '{8'h15, 2'b10, 8'h2A, 8'h15, 3'd0, 0};
    tbl[2] = '{8'h03, 2'b11, 8'h2A, 8'h15, 3'd3, 1};
    tbl[3] = '{8'h55, 2'b00, 8'h00, 8'h00, 3'd0, 0};
    tbl[4] = '{8'hFF, 2'b01, 8'hFF, 8'h00, 3'd0, 0};
    tbl[5] = '{8'h01, 2'b10, 8'hFF, 8'h01, 3'd0, 0};
    tbl[6] = '{8'hFF, 2'b11, 8'hFF, 8'h01, 3'd7, 1};
    tbl[7] = '{8'h33, 2'b00, 8'h00, 8'h00, 3'd0, 0};

    rst_n = 1'b0;
    KEY_confirma = 1'b1;
    SW = 8'h00;
    wait_cycles(3);
    check_all("reset", 2'b00, 8'h00, 8'h00, 3'd0);
    chk("reset.op_start", int'(op_start), 0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Full sequence then wrap from a saturated operand set.
    for (int i = 0; i < 8; i++) begin
      p0 = pulse_cnt;
      press(tbl[i].sw);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].op);
      chk($sformatf("vec%0d.op_start_pulses", i), pulse_cnt - p0, tbl[i].pulses);
    end

    // Latency from a clean fall (applied mid-cycle) to the state update.
    @(negedge clk);
    SW = 8'h2A;
    prev = state;
    KEY_confirma = 1'b0;
    cyc = 0;
    while (state == prev && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency_cycles", cyc, DEB + 3);
    wait_cycles(4);
    KEY_confirma = 1'b1;
    wait_cycles(12);
    check_all("latency_load", 2'b01, 8'h2A, 8'h00, 3'd0);

    // SW toggling in A_OK without a press changes nothing.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      SW = (i % 2 == 0) ? 8'hFF : 8'h00;
    end
    wait_cycles(3);
    check_all("sw_isolation", 2'b01, 8'h2A, 8'h00, 3'd0);

    // Reset in B_OK clears everything asynchronously.
    press(8'h15);
    chk("pre_reset.state", int'(state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 2'b00, 8'h00, 8'h00, 3'd0);
    chk("async_reset.op_start", int'(op_start), 0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(5);
    press(8'h80);
    check_all("after_reset", 2'b01, 8'h80, 8'h00, 3'd0);

    // Bounce in ESPERA_A: low 2, high 1, low 2, high -> no press.
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(5);
    SW = 8'h77;
    KEY_confirma = 1'b0; wait_cycles(2);
    KEY_confirma = 1'b1; wait_cycles(1);
    KEY_confirma = 1'b0; wait_cycles(2);
    KEY_confirma = 1'b1; wait_cycles(20);
    check_all("bounce", 2'b00, 8'h00, 8'h00, 3'd0);

    // Hold for 100 cycles: exactly one transition, none on release.
    @(negedge clk);
    SW = 8'h5A;
    KEY_confirma = 1'b0;
    trans = 0;
    prev = state;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state != prev) trans++;
      prev = state;
    end
    chk("hold.transitions", trans, 1);
    KEY_confirma = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state != prev) trans++;
      prev = state;
    end
    chk("hold.release_transitions", trans, 1);
    check_all("hold", 2'b01, 8'h5A, 8'h00, 3'd0);

    // Button held while reset releases: no press until released and pressed again.
    @(negedge clk);
    KEY_confirma = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(40);
    check_all("held_through_reset", 2'b00, 8'h00, 8'h00, 3'd0);
    KEY_confirma = 1'b1;
    wait_cycles(15);
    chk("held_release.state", int'(state), 0);
    press(8'h11);
    check_all("held_then_press", 2'b01, 8'h11, 8'h00, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_entradas.md
SEQUENCIADOR_ENTRADAS -- requirements
Module: sequenciador_entradas

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set how many consecutive stable clock cycles (1 ms at 50 MHz) a button level needs before it is accepted.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 KEY_confirma  input  1  SHALL be the raw, asynchronous, active-low confirm pushbutton.
REQ-005 SW  input  8  SHALL be the switch data: operand value, or opcode on SW[2:0].
REQ-006 state  output  2  SHALL be the current sequencing state, feeding the LED/display stage.
REQ-007 A_registered  output  8  SHALL be the latched operand A.
REQ-008 B_registered  output  8  SHALL be the latched operand B.
REQ-009 OP_registered  output  3  SHALL be the latched ALU opcode.
REQ-010 op_start  output  1  SHALL be a one-cycle strobe telling the ALU that A, B and OP are complete.

Function
REQ-011 KEY_confirma SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL update its stable level only when the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the stable level SHALL restart the count at 0.
REQ-013 A press SHALL be a one-cycle pulse raised on the cycle after the stable level goes from 1 to 0; the release (0 to 1) SHALL NOT produce a pulse.
REQ-014 A held button SHALL produce exactly one press; glitches shorter than DEBOUNCE_CYCLES SHALL produce none.
REQ-015 The FSM SHALL use four states: 00 ESPERA_A, 01 A_OK, 10 B_OK, 11 OP_OK.
REQ-016 When a press occurs in ESPERA_A, the FSM SHALL load A_registered<=SW and go to A_OK.
REQ-017 When a press occurs in A_OK, the FSM SHALL load B_registered<=SW and go to B_OK.
REQ-018 When a press occurs in B_OK, the FSM SHALL load OP_registered<=SW[2:0], go to OP_OK and assert op_start for exactly that same cycle.
REQ-019 When a press occurs in OP_OK, the FSM SHALL clear A, B and OP to 0 and return to ESPERA_A.
REQ-020 Each of these updates SHALL take effect on the clock edge where the press pulse is high (1-cycle latency from the pulse).
REQ-021 Without a press, the FSM SHALL hold its state and all registers; SW changes SHALL be ignored.
REQ-022 state, A_registered, B_registered and OP_registered SHALL be driven directly from flops, with no combinational path from SW.
REQ-023 Total latency from a clean KEY_confirma fall to the register/state update SHALL be DEBOUNCE_CYCLES+3 cycles (±1 for asynchronous input alignment).
REQ-024 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), and the counter SHALL saturate, never wrap.

Reset
REQ-025 While rst_n is low: state=00, A/B/OP=0, op_start=0, the debounce counter=0, and the synchronizer and stable level=1 (released).
REQ-026 A reset mid-sequence SHALL discard every partial entry; after rst_n rises the next accepted press SHALL load A.
REQ-027 A button already held while rst_n rises SHALL NOT generate a press until it is released and pressed again.

Structure
REQ-028 The state encodings (ESPERA_A, A_OK, B_OK, OP_OK) SHALL live in the shared ULA package and be reused by the LED/display stage.
REQ-029 Synchronizer, debounce and fall-edge detection SHALL form one sub-module, debounce_botao (ports clk, rst_n, btn_n, press), parameterized by DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Full sequence: SW=0x2A press, SW=0x15 press, SW=0x03 press -> A=0x2A, B=0x15, OP=3, state=11, op_start high for exactly 1 cycle.
REQ-031 Bounce: KEY low 2 cycles, high 1, low 2, then high in ESPERA_A -> no press, state stays 00, A=0.
REQ-032 Hold: KEY low for 100 cycles -> exactly one transition 00->01; releasing -> no further change.
REQ-033 Wrap: in OP_OK with A=0xFF, B=0x01, OP=7, press -> state=00, A=B=OP=0, op_start stays 0.
REQ-034 Reset mid-op: in B_OK, pulse rst_n low -> all outputs 0 immediately (asynchronous); next press with SW=0x80 -> A=0x80, state=01.
REQ-035 SW isolation: in A_OK, toggle SW 0x00<->0xFF without pressing -> A_registered and B_registered unchanged.
